// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps
// between a start pulse and a registered result with a one-cycle done pulse.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_mag_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_count;
    logic        r_a_neg;
    logic        r_b_neg;
    logic        r_b_zero;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;

    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [31:0] w_diff;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [63:0] w_prod;
    logic [63:0] w_prod_s;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fix;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // Operand signedness for the incoming op
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (op)
            3'b001, 3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'b010:                 begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
            default:                begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
    end

    // One iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : 33'd0);
        w_shift = {r_hi, r_lo[31]};
        w_diff  = w_shift[31:0] - r_mag_b;
        if (r_op[2]) begin
            if (w_shift >= {1'b0, r_mag_b}) begin
                w_hi_nxt = w_diff;
                w_lo_nxt = {r_lo[30:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[31:0];
                w_lo_nxt = {r_lo[30:0], 1'b0};
            end
        end else begin
            w_hi_nxt = w_sum[32:1];
            w_lo_nxt = {w_sum[0], r_lo[31:1]};
        end
    end

    // Sign correction and RV32M special cases
    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_s = (r_a_neg ^ r_b_neg) ? (64'd0 - w_prod) : w_prod;
        w_quo    = (r_a_neg ^ r_b_neg) ? (32'd0 - r_lo) : r_lo;
        w_rem    = r_a_neg ? (32'd0 - r_hi) : r_hi;
        case (r_op)
            3'b000:                 w_fix = w_prod_s[31:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod_s[63:32];
            3'b100, 3'b101:         w_fix = r_b_zero ? 32'hFFFF_FFFF : (r_ovf ? 32'h8000_0000 : w_quo);
            3'b110, 3'b111:         w_fix = r_b_zero ? r_a : (r_ovf ? 32'd0 : w_rem);
            default:                w_fix = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_CALC : S_IDLE;
            S_CALC:  w_next = (r_count == 5'd31) ? S_FIX : S_CALC;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode, registered alongside the state
    always_comb begin
        w_busy_nxt = (w_next != S_IDLE);
        w_done_nxt = (w_next == S_DONE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 3'd0;
            r_a      <= 32'd0;
            r_mag_b  <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_count  <= 5'd0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_a      <= a;
                        r_a_neg  <= w_a_signed & a[31];
                        r_b_neg  <= w_b_signed & b[31];
                        r_lo     <= (w_a_signed & a[31]) ? (32'd0 - a) : a;
                        r_mag_b  <= (w_b_signed & b[31]) ? (32'd0 - b) : b;
                        r_hi     <= 32'd0;
                        r_count  <= 5'd0;
                        r_b_zero <= (b == 32'd0);
                        r_ovf    <= w_b_signed & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
                    end
                end
                S_CALC: begin
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_count <= r_count + 5'd1;
                end
                S_FIX:   r_result <= w_fix;
                default: r_count  <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with a result scoreboard queue.
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          tests;
    int          fails;
    logic [31:0] sb[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic [31:0] t_exp, input string tag, input int poke_cyc);
        int          n;
        bit          got;
        bit          busy_bad;
        bit          extra;
        logic [31:0] exp_v;
        sb.push_back(t_exp);
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~t_op; a = ~t_a; b = t_a ^ 32'h5A5A_0F0F;
        n = 0; got = 1'b0; busy_bad = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == poke_cyc) begin
                start = 1'b1; a = $urandom; b = $urandom; op = 3'b000;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) got = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(n), 32'd33);
        check({tag, " busy_through_done"}, 32'(busy_bad), 32'd0);
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            check({tag, " result"}, result, exp_v);
        end else begin
            check({tag, " scoreboard_empty"}, 32'(sb.size()), 32'd1);
        end
        @(posedge clk);
        #1;
        check({tag, " done_single_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
        if (poke_cyc > 0) begin
            extra = 1'b0;
            repeat (36) begin
                @(posedge clk);
                #1;
                if (done !== 1'b0) extra = 1'b1;
            end
            check({tag, " no_queued_start"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        bit extra;
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL",         0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH",        0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU",      0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU",       0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "DIV",         0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "REM",         0);
        run_op(3'b101, 32'd100,       32'd7,         32'd14,        "DIVU",        0);
        run_op(3'b111, 32'd100,       32'd7,         32'd2,         "REMU",        0);
        run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "DIVU_by0",    0);
        run_op(3'b111, 32'd5,         32'd0,         32'd5,         "REMU_by0",    0);
        run_op(3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "DIV_by0",     0);
        run_op(3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "REM_by0",     0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV_ovf",     0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "REM_ovf",     0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "DIV_restart", 10);

        // Abort a divide with reset part-way through
        @(negedge clk);
        op = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) extra = 1'b1;
        end
        check("abort no_done", 32'(extra), 32'd0);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, "DIVU_after_abort", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
